// File: rtl/vga_pkg.sv
// Shared constants for the VGA time/date renderer: display size, glyph codes,
// edit-field encodings, colours and the 8x16 font table.
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  localparam logic [3:0] GLYPH_COLON = 4'd10;
  localparam logic [3:0] GLYPH_SLASH = 4'd11;
  localparam logic [3:0] GLYPH_BLANK = 4'd15;

  typedef enum logic [2:0] {
    FIELD_NONE     = 3'd0,
    FIELD_HOUR     = 3'd1,
    FIELD_MIN      = 3'd2,
    FIELD_SEC      = 3'd3,
    FIELD_DAY      = 3'd4,
    FIELD_MONTH    = 3'd5,
    FIELD_YEAR     = 3'd6,
    FIELD_NONE_ALT = 3'd7
  } field_e;

  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  localparam logic [11:0] RGB_NAVY  = 12'h008;

  // Digits are drawn as seven-segment shapes; segment order is a..g, a in the MSB.
  function automatic logic [7:0] font_row(input logic [3:0] code, input logic [3:0] row);
    logic [6:0] seg;
    logic [7:0] bits;
    seg  = 7'b0;
    bits = 8'h00;
    case (code)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0;
    endcase
    if (code <= 4'd9) begin
      case (row)
        4'd2: if (seg[6]) bits = 8'h7E;
        4'd3, 4'd4, 4'd5, 4'd6, 4'd7: bits = {1'b0, seg[1], 4'b0000, seg[5], 1'b0};
        4'd8: if (seg[0]) bits = 8'h7E;
        4'd9, 4'd10, 4'd11, 4'd12: bits = {1'b0, seg[2], 4'b0000, seg[4], 1'b0};
        4'd13: if (seg[3]) bits = 8'h7E;
        default: bits = 8'h00;
      endcase
    end else if (code == GLYPH_COLON) begin
      if (row == 4'd5 || row == 4'd6 || row == 4'd10 || row == 4'd11) bits = 8'h18;
    end else if (code == GLYPH_SLASH) begin
      if (row >= 4'd2 && row <= 4'd13) bits = 8'h02 << ((row - 4'd2) >> 1);
    end
    return bits;
  endfunction

endpackage

// File: rtl/vga_time_renderer_if.sv
// Pixel-coordinate and sync stream from the VGA sync generator.
interface vga_time_renderer_if;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic       hsync_in;
  logic       vsync_in;

  modport master (output px_x, px_y, hsync_in, vsync_in);
  modport slave  (input  px_x, px_y, hsync_in, vsync_in);
endinterface

// File: rtl/font_rom.sv
// 16 glyphs x 16 rows x 8 bits; one-clock registered read.
module font_rom (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code,
  input  logic [3:0] row,
  output logic [7:0] bits
);
  import vga_pkg::*;

  logic [7:0] bits_d, bits_q;

  always_comb bits_d = font_row(code, row);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bits_q <= 8'h00;
    else     bits_q <= bits_d;
  end

  assign bits = bits_q;
endmodule

// File: rtl/vga_time_renderer.sv
// Renders "HH:MM:SS" / "DD/MM/YY" as 2x-scaled glyphs; time is shadowed once per
// frame at the start of vertical blanking. Output latency is two clocks.
module vga_time_renderer #(
  parameter int          H_DISPLAY    = vga_pkg::H_DISPLAY,
  parameter int          V_DISPLAY    = vga_pkg::V_DISPLAY,
  parameter int          X0           = 256,
  parameter int          Y0           = 208,
  parameter logic [11:0] FG           = vga_pkg::RGB_WHITE,
  parameter logic [11:0] BG           = vga_pkg::RGB_NAVY,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  vga_time_renderer_if.slave        vid,
  input  logic [7:0]                hour,
  input  logic [7:0]                minute,
  input  logic [7:0]                second,
  input  logic [7:0]                day,
  input  logic [7:0]                month,
  input  logic [7:0]                year,
  input  logic [2:0]                edit_field,
  output logic [11:0]               rgb,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      frame_start
);
  import vga_pkg::*;

  localparam logic [9:0] X0_V       = 10'(X0);
  localparam logic [9:0] Y0_V       = 10'(Y0);
  localparam logic [9:0] H_V        = 10'(H_DISPLAY);
  localparam logic [9:0] V_V        = 10'(V_DISPLAY);
  localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

  // frame-coherent shadow state
  logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [7:0] day_q, day_d, mon_q, mon_d, year_q, year_d;
  field_e     edit_q, edit_d;
  logic [5:0] blink_cnt_q, blink_cnt_d;
  logic       blink_on_q, blink_on_d;
  logic       cap_prev_q, cap_prev_d;
  logic       frame_start_q, frame_start_d;
  logic       cap_cond, cap;

  // S0 combinational
  logic [9:0] dx, dy;
  logic       in_box, active, line_sel, blanked;
  logic [2:0] chr, bit_col;
  logic [3:0] glyph_row, nib, code;
  logic [7:0] pair;
  field_e     fld;

  // S1 / S2 registers
  logic [7:0]  glyph_bits;
  logic [2:0]  bit_col_q, bit_col_d;
  logic        in_box_q, in_box_d, active_q, active_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d;

  always_comb begin
    cap_cond      = (vid.px_x == 10'd0) && (vid.px_y == V_V);
    cap           = cap_cond && !cap_prev_q;
    cap_prev_d    = cap_cond;
    frame_start_d = cap;
    hour_d        = hour_q;
    min_d         = min_q;
    sec_d         = sec_q;
    day_d         = day_q;
    mon_d         = mon_q;
    year_d        = year_q;
    edit_d        = edit_q;
    blink_cnt_d   = blink_cnt_q;
    blink_on_d    = blink_on_q;
    if (cap) begin
      hour_d = hour;
      min_d  = minute;
      sec_d  = second;
      day_d  = day;
      mon_d  = month;
      year_d = year;
      edit_d = field_e'(edit_field);
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 6'd0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 6'd1;
      end
    end
  end

  // Left/above the box wraps to a large unsigned offset, so one compare per axis suffices.
  always_comb begin
    dx        = vid.px_x - X0_V;
    dy        = vid.px_y - Y0_V;
    in_box    = (dx < 10'd128) && (dy < 10'd64);
    active    = (vid.px_x < H_V) && (vid.px_y < V_V);
    chr       = dx[6:4];
    line_sel  = dy[5];
    glyph_row = dy[4:1];
    bit_col   = dx[3:1];
    pair      = 8'h00;
    fld       = FIELD_NONE;
    case (chr)
      3'd0, 3'd1: begin
        pair = line_sel ? day_q : hour_q;
        fld  = line_sel ? FIELD_DAY : FIELD_HOUR;
      end
      3'd3, 3'd4: begin
        pair = line_sel ? mon_q : min_q;
        fld  = line_sel ? FIELD_MONTH : FIELD_MIN;
      end
      3'd6, 3'd7: begin
        pair = line_sel ? year_q : sec_q;
        fld  = line_sel ? FIELD_YEAR : FIELD_SEC;
      end
      default: ;
    endcase
    nib     = (chr == 3'd0 || chr == 3'd3 || chr == 3'd6) ? pair[7:4] : pair[3:0];
    blanked = !blink_on_q && (fld != FIELD_NONE) && (fld == edit_q);
    if (chr == 3'd2 || chr == 3'd5) code = line_sel ? GLYPH_SLASH : GLYPH_COLON;
    else if (nib > 4'd9 || blanked) code = GLYPH_BLANK;
    else                            code = nib;
  end

  font_rom u_font (
    .clk  (clk),
    .rst  (rst),
    .code (code),
    .row  (glyph_row),
    .bits (glyph_bits)
  );

  always_comb begin
    bit_col_d = bit_col;
    in_box_d  = in_box;
    active_d  = active;
    hs1_d     = vid.hsync_in;
    vs1_d     = vid.vsync_in;
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;
    if (!active_q)                         rgb_d = RGB_BLACK;
    else if (!in_box_q)                    rgb_d = BG;
    else if (glyph_bits[3'd7 - bit_col_q]) rgb_d = FG;
    else                                   rgb_d = BG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour_q        <= 8'h00;
      min_q         <= 8'h00;
      sec_q         <= 8'h00;
      day_q         <= 8'h00;
      mon_q         <= 8'h00;
      year_q        <= 8'h00;
      edit_q        <= FIELD_NONE;
      blink_cnt_q   <= 6'd0;
      blink_on_q    <= 1'b1;
      cap_prev_q    <= 1'b0;
      frame_start_q <= 1'b0;
      bit_col_q     <= 3'd0;
      in_box_q      <= 1'b0;
      active_q      <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      rgb_q         <= RGB_BLACK;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
    end else begin
      hour_q        <= hour_d;
      min_q         <= min_d;
      sec_q         <= sec_d;
      day_q         <= day_d;
      mon_q         <= mon_d;
      year_q        <= year_d;
      edit_q        <= edit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      cap_prev_q    <= cap_prev_d;
      frame_start_q <= frame_start_d;
      bit_col_q     <= bit_col_d;
      in_box_q      <= in_box_d;
      active_q      <= active_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      rgb_q         <= rgb_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync_out   = hs2_q;
  assign vsync_out   = vs2_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_time_renderer.sv
// Scoreboard bench: the driver pushes model expectations, a negedge monitor pops and compares.
module tb_vga_time_renderer;
  import vga_pkg::*;

  localparam int          X0    = 256;
  localparam int          Y0    = 208;
  localparam int          BLINK = 30;
  localparam logic [11:0] FG    = 12'hFFF;
  localparam logic [11:0] BG    = 12'h008;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_time_renderer_if vid();
  logic [7:0]  hour = 8'h00, minute = 8'h00, second = 8'h00;
  logic [7:0]  day = 8'h00, month = 8'h00, year = 8'h00;
  logic [2:0]  edit_field = 3'd0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, frame_start;

  vga_time_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .vid         (vid),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .day         (day),
    .month       (month),
    .year        (year),
    .edit_field  (edit_field),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .frame_start (frame_start)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int x; int y; logic [11:0] rgb; logic hs; logic vs; } pix_t;
  typedef struct { int due; logic fs; } fs_t;
  pix_t pix_q[$];
  fs_t  fs_q[$];

  // reference state: values latched at the last capture and number of captures since reset
  logic [7:0] m_val [6];
  int         m_edit  = 0;
  int         m_caps  = 0;
  logic       m_prev  = 1'b0;
  int         sync_lo = 0;

  task automatic check(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] model_pixel(int x, int y);
    int cx, cy, ch, ln, grow, gcol, fidx, nib;
    logic       blink_on;
    logic [3:0] code;
    logic [7:0] r;
    if (x >= 640 || y >= 480) return 12'h000;
    if (x < X0 || x >= X0 + 128 || y < Y0 || y >= Y0 + 64) return BG;
    cx = (x - X0) / 2;
    cy = (y - Y0) / 2;
    ch = cx / 8;
    ln = cy / 16;
    grow = cy % 16;
    gcol = cx % 8;
    blink_on = ((m_caps / BLINK) % 2) == 0;
    if (ch == 2 || ch == 5) begin
      code = (ln != 0) ? GLYPH_SLASH : GLYPH_COLON;
    end else begin
      fidx = ln * 3 + ch / 3;
      nib  = (ch % 3 == 0) ? int'(m_val[fidx]) / 16 : int'(m_val[fidx]) % 16;
      if (nib > 9 || (!blink_on && m_edit == fidx + 1)) code = GLYPH_BLANK;
      else code = nib[3:0];
    end
    r = font_row(code, grow[3:0]);
    return r[7 - gcol] ? FG : BG;
  endfunction

  task automatic drive(int x, int y);
    pix_t p;
    fs_t  f;
    logic hs, vs, cond, cap;
    @(posedge clk);
    #1;
    hs = (sync_lo != 0) ? 1'b0 : 1'($urandom_range(0, 1));
    vs = (sync_lo != 0) ? 1'b0 : 1'($urandom_range(0, 1));
    vid.px_x = x[9:0];
    vid.px_y = y[9:0];
    vid.hsync_in = hs;
    vid.vsync_in = vs;
    p.due = cyc + 2; p.x = x; p.y = y; p.rgb = model_pixel(x, y); p.hs = hs; p.vs = vs;
    pix_q.push_back(p);
    cond = (x == 0 && y == 480);
    cap  = cond && !m_prev;
    m_prev = cond;
    f.due = cyc + 1; f.fs = cap;
    fs_q.push_back(f);
    if (cap) begin
      m_val[0] = hour;  m_val[1] = minute; m_val[2] = second;
      m_val[3] = day;   m_val[4] = month;  m_val[5] = year;
      m_edit = int'(edit_field);
      m_caps++;
    end
  endtask

  task automatic capture_frame();
    drive(639, 479);
    repeat (3) drive(0, 480);
    drive(1, 480);
  endtask

  task automatic render_rows(int n, int ylo, int yhi);
    for (int r = 0; r < n; r++) begin
      int y;
      y = int'($urandom_range(ylo, yhi));
      for (int x = X0 - 2; x < X0 + 130; x++) drive(x, y);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (pix_q.size() != 0 || fs_q.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic reset_checks();
    check("rst_rgb", int'(rgb), 0);
    check("rst_hsync", int'(hsync_out), 1);
    check("rst_vsync", int'(vsync_out), 1);
    check("rst_fs", int'(frame_start), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_val[i] = 8'h00;
    m_edit = 0;
    m_caps = 0;
    m_prev = 1'b0;
  endtask

  pix_t mp;
  fs_t  mf;
  always @(negedge clk) begin
    while (pix_q.size() != 0 && pix_q[0].due <= cyc) begin
      mp = pix_q.pop_front();
      check("due", cyc, mp.due);
      check($sformatf("rgb(%0d,%0d)", mp.x, mp.y), int'(rgb), int'(mp.rgb));
      check("hsync_out", int'(hsync_out), int'(mp.hs));
      check("vsync_out", int'(vsync_out), int'(mp.vs));
    end
    while (fs_q.size() != 0 && fs_q[0].due <= cyc) begin
      mf = fs_q.pop_front();
      check("frame_start", int'(frame_start), int'(mf.fs));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    vid.px_x = 10'd300;
    vid.px_y = 10'd220;
    vid.hsync_in = 1'b1;
    vid.vsync_in = 1'b1;
    #1 rst = 1'b1;
    #1 reset_checks();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // full box plus boundary pixels with a known time
    hour = 8'h12; minute = 8'h34; second = 8'h56;
    day = 8'h25; month = 8'h12; year = 8'h24;
    capture_frame();
    for (int y = Y0 - 1; y < Y0 + 65; y++)
      for (int x = X0 - 2; x < X0 + 130; x++) drive(x, y);
    drive(700, 220);
    drive(X0 - 1, Y0);

    // input change mid-frame stays invisible until the next capture
    drive(5, 100);
    minute = 8'h35;
    render_rows(4, Y0, Y0 + 31);
    capture_frame();
    render_rows(4, Y0, Y0 + 31);

    // reset in the middle of a frame
    sync_lo = 1;
    drive(300, 220);
    drive(300, 220);
    sync_lo = 0;
    drain();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_checks();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    drive(300, 220);
    render_rows(2, Y0, Y0 + 63);

    // minute field blinks with a 30-frame half period
    edit_field = 3'd2;
    for (int f = 0; f < 62; f++) begin
      capture_frame();
      render_rows(2, Y0 + 4, Y0 + 27);
    end

    // invalid BCD digits render as background
    edit_field = 3'd0;
    day = 8'hAF;
    capture_frame();
    render_rows(3, Y0 + 36, Y0 + 59);

    // random values and random pixels anywhere on the raster
    for (int f = 0; f < 6; f++) begin
      hour = 8'($urandom); minute = 8'($urandom); second = 8'($urandom);
      day = 8'($urandom); month = 8'($urandom); year = 8'($urandom);
      edit_field = 3'($urandom_range(0, 7));
      capture_frame();
      for (int i = 0; i < 400; i++) begin
        if (i % 2 == 0) drive(int'($urandom_range(X0 - 4, X0 + 131)), int'($urandom_range(Y0 - 4, Y0 + 67)));
        else            drive(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      end
    end

    drain();
    check("pix_q_left", pix_q.size(), 0);
    check("fs_q_left", fs_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
